fpu_mds_seq_ctrl: RTL and testbench
===================================

FPU_MDS_SEQ_CTRL -- requirements
Module: fpu_mds_seq_ctrl

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width; W = 1+EXP_W+MAN_W.
REQ-002 SHALL have parameter MAN_W, default 23, fraction width.
REQ-003 SHALL have parameter MUL_LAT, default 2, multiplier pipeline depth in cycles (legal range >=1).
REQ-004 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, request valid.
REQ-007 SHALL have port in_ready, output, 1, controller can accept a request.
REQ-008 SHALL have port op_sel, input, 2, operation: 00 mul, 01 div, 10 sqrt, 11 reserved.
REQ-009 SHALL have ports op_a and op_b, input, W each, IEEE-754 operands; sqrt uses op_a only.
REQ-010 SHALL have ports div_rdy and sqrt_rdy, input, 1 each, iterative unit done.
REQ-011 SHALL have ports div_start and sqrt_start, output, 1 each, single-cycle start pulses.
REQ-012 SHALL have port res_en, output, 1, datapath result-register enable.
REQ-013 SHALL have port res_sel, output, 2, result source: 00 mul, 01 div, 10 sqrt, 11 fast_res.
REQ-014 SHALL have port fast_res, output, W, special-case result.
REQ-015 SHALL have port flags, output, 3, {invalid, divzero, overflow}.
REQ-016 SHALL have port out_valid, output, 1, response valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts the response.
REQ-018 SHALL have port busy, output, 1, high when the FSM is not in IDLE.

Function
REQ-019 SHALL classify each operand: zero = exponent 0 and fraction 0; inf = exponent all-ones and fraction 0; NaN = exponent all-ones and fraction nonzero; sNaN = NaN with fraction MSB 0; subnormals are treated as finite nonzero.
REQ-020 SHALL set mul fast cases: any NaN -> NaN; 0*inf -> qNaN with invalid; inf*finite or inf*inf -> inf with sign sA^sB; 0*finite -> zero with sign sA^sB.
REQ-021 SHALL set div fast cases: any NaN -> NaN; 0/0 and inf/inf -> qNaN with invalid; finite nonzero/0 -> inf with sign sA^sB and divzero; inf/finite -> signed inf; 0/x and finite/inf -> zero with sign sA^sB.
REQ-022 SHALL set sqrt fast cases: NaN -> NaN; +/-0 -> same zero; +inf -> +inf; any negative nonzero, including -inf -> qNaN with invalid.
REQ-023 SHALL raise invalid for any sNaN input; overflow SHALL never be raised on the fast path; op_sel 11 -> +0 with invalid.
REQ-024 SHALL run the FSM through states IDLE, MUL_WAIT, ITER_START, ITER_WAIT, RESP; in_ready = (state==IDLE).
REQ-025 SHALL, on acceptance (in_valid & in_ready), register the op and operands and go to: RESP if fast (res_sel 11, fast_res and flags registered); MUL_WAIT if mul; ITER_START if div or sqrt.
REQ-026 SHALL, in MUL_WAIT, count MUL_LAT cycles, pulse res_en in the last cycle, then go to RESP; res_sel 00.
REQ-027 SHALL, in ITER_START, pulse div_start or sqrt_start for exactly 1 cycle; any rdy seen in this cycle SHALL be ignored.
REQ-028 SHALL, in ITER_WAIT, assert res_en in the cycle the matching rdy is seen, then go to RESP; non-matching rdy SHALL be ignored.
REQ-029 SHALL, in RESP, assert out_valid and hold res_sel, fast_res and flags stable until out_ready, then return to IDLE; a new request SHALL not be accepted in that same cycle.
REQ-030 SHALL produce flags = 0 for non-fast results; latency from acceptance to out_valid SHALL be 1 cycle (fast) and MUL_LAT+1 cycles (mul).

Reset
REQ-031 SHALL, when reset is asserted, force state IDLE, counter 0, and all outputs 0 except in_ready = 1; this applies mid-operation, abandoning any pending op and its rdy.

Configuration
REQ-032 SHALL, when FPU_MDS_CANON_NAN_EN is defined, output every NaN result as canonical {0, all-ones, 1, zeros}.
REQ-033 SHALL, when FPU_MDS_CANON_NAN_EN is undefined, propagate the first NaN operand (A before B) with its quiet bit forced to 1, and produce the canonical qNaN only for invalid-generated NaNs.

Structure
REQ-034 SHALL place the op_sel and res_sel encodings, the FSM state encoding, the flag bit indices and a qNaN constant function of (EXP_W, MAN_W) in package fpu_mds_pkg.
REQ-035 SHALL instantiate sub-module fpu_mds_classify, parametrised by EXP_W/MAN_W, once per operand.

Verification
REQ-036 SHALL cover: MUL_LAT=3, mul 2.0*3.0 (0x40000000, 0x40400000) -> res_en in cycle 3, out_valid in cycle 4, res_sel 00, flags 000.
REQ-037 SHALL cover: div 1.0/+0 (0x3F800000, 0x00000000) -> out_valid next cycle, fast_res 0x7F800000, flags 010.
REQ-038 SHALL cover: sqrt -4.0 (0xC0800000) -> fast_res 0x7FC00000, flags 100; sqrt -0 -> 0x80000000, flags 000.
REQ-039 SHALL cover: mul sNaN 0x7F800001 * 1.0 -> invalid set; with macro 0x7FC00000, without macro 0x7FC00001.
REQ-040 SHALL cover: div 6.0/2.0 with div_rdy high during ITER_START and again 5 cycles later -> div_start pulses once, res_en on the second rdy, out_valid held 3 cycles while out_ready is low.
REQ-041 SHALL cover: reset asserted in ITER_WAIT -> all outputs 0 and in_ready 1 immediately; a later div_rdy produces no response.

Source files
------------

// File: rtl/fpu_mds_pkg.sv
// fpu_mds_pkg: shared encodings, FSM states, flag indices and qNaN constant for the mul/div/sqrt sequencer
package fpu_mds_pkg;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_SQRT = 2'b10, OP_RSV = 2'b11} op_e;
    typedef enum logic [1:0] {RS_MUL = 2'b00, RS_DIV = 2'b01, RS_SQRT = 2'b10, RS_FAST = 2'b11} res_sel_e;
    typedef enum logic [2:0] {ST_IDLE, ST_MUL_WAIT, ST_ITER_START, ST_ITER_WAIT, ST_RESP} state_e;
    localparam int FLG_INV = 2;
    localparam int FLG_DZ  = 1;
    localparam int FLG_OVF = 0;
    // canonical quiet NaN {0, all-ones exponent, 1, zeros}; callers truncate to their width
    function automatic logic [63:0] qnan_const(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction
endpackage

// File: rtl/fpu_mds_seq_ctrl_if.sv
// fpu_mds_seq_ctrl_if: request/response bus between a requester (master) and the sequencer (slave)
interface fpu_mds_seq_ctrl_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
    localparam int W = 1 + EXP_W + MAN_W;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op_sel;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   res_sel;
    logic [W-1:0] fast_res;
    logic [2:0]   flags;
    modport master (
        output in_valid, op_sel, op_a, op_b, out_ready,
        input  in_ready, out_valid, res_sel, fast_res, flags
    );
    modport slave (
        input  in_valid, op_sel, op_a, op_b, out_ready,
        output in_ready, out_valid, res_sel, fast_res, flags
    );
endinterface

// File: rtl/fpu_mds_classify.sv
// fpu_mds_classify: IEEE-754 operand class decode (subnormals count as finite nonzero)
module fpu_mds_classify #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_x,
    output logic                 o_sign,
    output logic                 o_zero,
    output logic                 o_inf,
    output logic                 o_nan,
    output logic                 o_snan
);
    logic w_exp_zero;
    logic w_exp_ones;
    logic w_man_zero;
    assign w_exp_zero = i_x[MAN_W +: EXP_W] == '0;
    assign w_exp_ones = &i_x[MAN_W +: EXP_W];
    assign w_man_zero = i_x[MAN_W-1:0] == '0;
    assign o_sign     = i_x[EXP_W+MAN_W];
    assign o_zero     = w_exp_zero & w_man_zero;
    assign o_inf      = w_exp_ones & w_man_zero;
    assign o_nan      = w_exp_ones & ~w_man_zero;
    assign o_snan     = o_nan & ~i_x[MAN_W-1];
endmodule

// File: rtl/fpu_mds_seq_ctrl.sv
// fpu_mds_seq_ctrl: sequencer for mul/div/sqrt with special-case fast path.
// Define FPU_MDS_CANON_NAN_EN to emit every NaN result as the canonical qNaN.
module fpu_mds_seq_ctrl
    import fpu_mds_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    fpu_mds_seq_ctrl_if.slave bus,
    input  logic              div_rdy,
    input  logic              sqrt_rdy,
    output logic              div_start,
    output logic              sqrt_start,
    output logic              res_en,
    output logic              busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [W-1:0] QNAN = W'(qnan_const(EXP_W, MAN_W));
    localparam logic [W-1:0] QBIT = W'(1) << (MAN_W - 1);

    state_e       r_state;
    state_e       w_next;
    op_e          r_op;
    res_sel_e     r_res_sel;
    logic [CW-1:0] r_cnt;
    logic [W-1:0] r_fast_res;
    logic [2:0]   r_flags;

    logic w_a_sign, w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic w_b_sign, w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic         w_sgn;
    logic         w_acc;
    logic         w_fast;
    logic [W-1:0] w_fres;
    logic [2:0]   w_fflg;
    logic [W-1:0] w_nan_res;
    logic         w_cnt_last;
    logic         w_rdy;

    fpu_mds_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_x(bus.op_a), .o_sign(w_a_sign), .o_zero(w_a_zero), .o_inf(w_a_inf), .o_nan(w_a_nan), .o_snan(w_a_snan)
    );
    fpu_mds_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_x(bus.op_b), .o_sign(w_b_sign), .o_zero(w_b_zero), .o_inf(w_b_inf), .o_nan(w_b_nan), .o_snan(w_b_snan)
    );

    assign w_sgn      = w_a_sign ^ w_b_sign;
    assign w_acc      = bus.in_valid & (r_state == ST_IDLE);
    assign w_cnt_last = r_cnt == CW'(MUL_LAT - 1);
    assign w_rdy      = (r_op == OP_DIV) ? div_rdy : sqrt_rdy;

`ifdef FPU_MDS_CANON_NAN_EN
    assign w_nan_res = QNAN;
`else
    assign w_nan_res = (w_a_nan ? bus.op_a : bus.op_b) | QBIT;
`endif

    // special-case detection and result for the operation being offered
    always_comb begin
        w_fast = 1'b1;
        w_fres = '0;
        w_fflg = '0;
        case (bus.op_sel)
            OP_MUL: begin
                if (w_a_nan | w_b_nan) begin
                    w_fres          = w_nan_res;
                    w_fflg[FLG_INV] = w_a_snan | w_b_snan;
                end else if ((w_a_zero & w_b_inf) | (w_a_inf & w_b_zero)) begin
                    w_fres          = QNAN;
                    w_fflg[FLG_INV] = 1'b1;
                end else if (w_a_inf | w_b_inf)
                    w_fres = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (w_a_zero | w_b_zero)
                    w_fres = {w_sgn, {(W-1){1'b0}}};
                else
                    w_fast = 1'b0;
            end
            OP_DIV: begin
                if (w_a_nan | w_b_nan) begin
                    w_fres          = w_nan_res;
                    w_fflg[FLG_INV] = w_a_snan | w_b_snan;
                end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
                    w_fres          = QNAN;
                    w_fflg[FLG_INV] = 1'b1;
                end else if (w_a_inf)
                    w_fres = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (w_b_zero) begin
                    w_fres         = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_fflg[FLG_DZ] = 1'b1;
                end else if (w_a_zero | w_b_inf)
                    w_fres = {w_sgn, {(W-1){1'b0}}};
                else
                    w_fast = 1'b0;
            end
            OP_SQRT: begin
                if (w_a_nan) begin
                    w_fres          = w_nan_res;
                    w_fflg[FLG_INV] = w_a_snan;
                end else if (w_a_zero)
                    w_fres = bus.op_a;
                else if (w_a_sign) begin
                    w_fres          = QNAN;
                    w_fflg[FLG_INV] = 1'b1;
                end else if (w_a_inf)
                    w_fres = bus.op_a;
                else
                    w_fast = 1'b0;
            end
            default: w_fflg[FLG_INV] = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_acc) w_next = w_fast ? ST_RESP : (bus.op_sel == OP_MUL) ? ST_MUL_WAIT : ST_ITER_START;
            ST_MUL_WAIT:   if (w_cnt_last) w_next = ST_RESP;
            ST_ITER_START: w_next = ST_ITER_WAIT;
            ST_ITER_WAIT:  if (w_rdy) w_next = ST_RESP;
            ST_RESP:       if (bus.out_ready) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // FSM outputs; rdy during ITER_START is ignored because only ITER_WAIT looks at it
    always_comb begin
        bus.in_ready  = r_state == ST_IDLE;
        busy          = r_state != ST_IDLE;
        div_start     = (r_state == ST_ITER_START) && (r_op == OP_DIV);
        sqrt_start    = (r_state == ST_ITER_START) && (r_op == OP_SQRT);
        res_en        = ((r_state == ST_MUL_WAIT) && w_cnt_last) || ((r_state == ST_ITER_WAIT) && w_rdy);
        bus.out_valid = r_state == ST_RESP;
    end

    // capture op and response fields on acceptance; count multiplier cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op       <= OP_MUL;
            r_cnt      <= '0;
            r_res_sel  <= RS_MUL;
            r_fast_res <= '0;
            r_flags    <= '0;
        end else if (w_acc) begin
            r_op       <= op_e'(bus.op_sel);
            r_cnt      <= '0;
            r_res_sel  <= w_fast ? RS_FAST : res_sel_e'(bus.op_sel);
            r_fast_res <= w_fast ? w_fres : '0;
            r_flags    <= w_fast ? w_fflg : '0;
        end else if (r_state == ST_MUL_WAIT)
            r_cnt <= r_cnt + CW'(1);
    end

    assign bus.res_sel  = r_res_sel;
    assign bus.fast_res = r_fast_res;
    assign bus.flags    = r_flags;
endmodule

// File: tb/tb_fpu_mds_seq_ctrl.sv
// tb_fpu_mds_seq_ctrl: directed scoreboard bench for fpu_mds_seq_ctrl (MUL_LAT=3); honours FPU_MDS_CANON_NAN_EN
module tb_fpu_mds_seq_ctrl;
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic div_rdy = 1'b0;
    logic sqrt_rdy = 1'b0;
    logic div_start, sqrt_start, res_en, busy;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    fpu_mds_seq_ctrl_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_mds_seq_ctrl #(.EXP_W(8), .MAN_W(23), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .bus(bus), .div_rdy(div_rdy), .sqrt_rdy(sqrt_rdy),
        .div_start(div_start), .sqrt_start(sqrt_start), .res_en(res_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed response, expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sel"}, bus.res_sel, e.sel);
            chk({tag, "_res"}, bus.fast_res, e.res);
            chk({tag, "_flg"}, bus.flags, e.flg);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat);
        int lat = 1;
        #1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (bus.out_valid) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_in_ready"}, bus.in_ready, 0);
            pop_cmp(tag);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no out_valid, expected response", tag);
        end
    endtask

    task automatic fast(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [2:0] flg);
        sb.push_back('{sel: 2'b11, res: res, flg: flg});
        send(op, a, b);
        wait_resp(tag, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_sel    = 2'b00;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_starts", {div_start, sqrt_start, res_en}, 0);
        chk("rst_res_sel", bus.res_sel, 0);
        chk("rst_fast_res", bus.fast_res, 0);
        chk("rst_flags", bus.flags, 0);
        @(negedge clk);
        reset = 1'b1;

        sb.push_back('{sel: 2'b00, res: 32'h0, flg: 3'b000});
        send(2'b00, 32'h40000000, 32'h40400000);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            chk($sformatf("mul_res_en_c%0d", c), res_en, c == 3);
            chk($sformatf("mul_out_valid_c%0d", c), bus.out_valid, c == 4);
            chk($sformatf("mul_busy_c%0d", c), busy, 1);
        end
        chk("mul_in_ready_resp", bus.in_ready, 0);
        pop_cmp("mul");

        fast("div_1_by_0", 2'b01, 32'h3F800000, 32'h00000000, 32'h7F800000, 3'b010);
        fast("sqrt_neg4", 2'b10, 32'hC0800000, 32'h0, 32'h7FC00000, 3'b100);
        fast("sqrt_neg0", 2'b10, 32'h80000000, 32'h0, 32'h80000000, 3'b000);
`ifdef FPU_MDS_CANON_NAN_EN
        fast("mul_snan", 2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100);
        fast("mul_qnan_b", 2'b00, 32'h3F800000, 32'hFFC00123, 32'h7FC00000, 3'b000);
`else
        fast("mul_snan", 2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 3'b100);
        fast("mul_qnan_b", 2'b00, 32'h3F800000, 32'hFFC00123, 32'hFFC00123, 3'b000);
`endif
        fast("mul_0_inf", 2'b00, 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100);
        fast("mul_ninf_2", 2'b00, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
        fast("mul_n0_3", 2'b00, 32'h80000000, 32'h40400000, 32'h80000000, 3'b000);
        fast("div_inf_inf", 2'b01, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100);
        fast("div_n0_5", 2'b01, 32'h80000000, 32'h40A00000, 32'h80000000, 3'b000);
        fast("div_1_ninf", 2'b01, 32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000);
        fast("div_ninf_0", 2'b01, 32'hFF800000, 32'h00000000, 32'hFF800000, 3'b000);
        fast("sqrt_pinf", 2'b10, 32'h7F800000, 32'h0, 32'h7F800000, 3'b000);
        fast("op_rsv", 2'b11, 32'h40000000, 32'h40000000, 32'h00000000, 3'b100);

        sb.push_back('{sel: 2'b01, res: 32'h0, flg: 3'b000});
        send(2'b01, 32'h40C00000, 32'h40000000);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            div_rdy       = (c == 1) || (c == 6);
            sqrt_rdy      = (c == 4);
            bus.out_ready = (c >= 10);
            #1;
            chk($sformatf("div_start_c%0d", c), div_start, c == 1);
            chk($sformatf("div_res_en_c%0d", c), res_en, c == 6);
            chk($sformatf("div_out_valid_c%0d", c), bus.out_valid, c >= 7);
            if (c == 1) chk("div_sqrt_start", sqrt_start, 0);
            if (c == 10) pop_cmp("div_iter");
        end
        @(negedge clk);
        div_rdy = 1'b0;
        #1;
        chk("div_back_idle", bus.in_ready, 1);

        sb.push_back('{sel: 2'b10, res: 32'h0, flg: 3'b000});
        send(2'b10, 32'h40800000, 32'h0);
        #1;
        chk("sqrt_start", sqrt_start, 1);
        chk("sqrt_no_div_start", div_start, 0);
        @(negedge clk);
        sqrt_rdy = 1'b1;
        #1;
        chk("sqrt_res_en", res_en, 1);
        @(negedge clk);
        sqrt_rdy = 1'b0;
        wait_resp("sqrt_iter", 1);

        send(2'b01, 32'h40C00000, 32'h40000000);
        @(negedge clk);
        #1;
        chk("rst_mid_busy_before", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstm_in_ready", bus.in_ready, 1);
        chk("rstm_busy", busy, 0);
        chk("rstm_out_valid", bus.out_valid, 0);
        chk("rstm_starts", {div_start, sqrt_start, res_en}, 0);
        chk("rstm_res_sel", bus.res_sel, 0);
        chk("rstm_flags", bus.flags, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        div_rdy = 1'b1;
        #1;
        chk("rstm_rdy_res_en", res_en, 0);
        @(negedge clk);
        div_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstm_no_resp_%0d", c), bus.out_valid, 0);
            chk($sformatf("rstm_idle_%0d", c), bus.in_ready, 1);
        end
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
